riscv_hazard_control: RTL

RISCV_HAZARD_CONTROL -- requirements
Module: riscv_hazard_control

---
 rtl/riscv_hazard_control.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/riscv_hazard_control.sv
// riscv_hazard_control: redirect/flush and load-use stall control for a 5-stage RISC-V pipeline.
//
// Purpose:
//   Resolves branches/jumps in EX and raises pc_src + flush. Detects load-use hazards between
//   EX and ID and raises stall + bubble. A small FSM (IDLE/FLUSH/STALL) stretches flush for
//   FLUSH_STAGES cycles and stall for LOAD_STALL_CYCLES cycles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid                   EX instruction valid
//   ex_opcode, ex_func3        EX instruction decode fields
//   ex_rs1_data, ex_rs2_data   forwarded branch operands (XLEN)
//   ex_is_load, ex_rd          EX load flag and destination register
//   id_rs1, id_rs2             ID source registers
//   id_uses_rs1, id_uses_rs2   ID source actually read
//   pc_src                     select redirect target (one cycle per redirect)
//   flush                      kill IF/ID and ID/EX
//   stall, bubble              hold PC and IF/ID, insert NOP into ID/EX
//   stall_cnt, flush_cnt       performance counters (CNT_W)
//
// Configuration:
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt counts stall cycles and flush_cnt counts
//                       redirects, both saturating; when undefined both are tied to zero.

module riscv_hazard_control #(
  parameter int unsigned XLEN              = 32,
  parameter int unsigned FLUSH_STAGES      = 2,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_func3,
  input  logic [XLEN-1:0]  ex_rs1_data,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  output logic             pc_src,
  output logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [1:0] FlushInit = 2'(FLUSH_STAGES - 1);
  localparam logic [1:0] StallInit = 2'(LOAD_STALL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StStall} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic eq, lt, ltu, br_taken, redirect, hazard;
  logic pc_src_c, flush_c, stall_c;

  // Branch comparison over the full operand width
  assign eq  = (ex_rs1_data == ex_rs2_data);
  assign lt  = ($signed(ex_rs1_data) < $signed(ex_rs2_data));
  assign ltu = (ex_rs1_data < ex_rs2_data);

  always_comb begin
    br_taken = 1'b0;
    unique case (ex_func3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign redirect = ex_valid &&
                    ((ex_opcode == OpJal) || (ex_opcode == OpJalr) ||
                     ((ex_opcode == OpBranch) && br_taken));

  assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_src_c = 1'b0;
    flush_c  = 1'b0;
    stall_c  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_src_c = 1'b1;
          flush_c  = 1'b1;
          state_d  = (FLUSH_STAGES > 1) ? StFlush : StIdle;
          cnt_d    = FlushInit;
        end else if (hazard) begin
          stall_c = 1'b1;
          state_d = (LOAD_STALL_CYCLES > 1) ? StStall : StIdle;
          cnt_d   = StallInit;
        end
      end
      StStall: begin
        // A redirect aborts the stall; hazards are not re-evaluated here
        if (redirect) begin
          pc_src_c = 1'b1;
          flush_c  = 1'b1;
          state_d  = (FLUSH_STAGES > 1) ? StFlush : StIdle;
          cnt_d    = FlushInit;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = StIdle;
        end
      end
      StFlush: begin
        // Wrong-path instructions: all EX/ID inputs ignored
        flush_c = 1'b1;
        cnt_d   = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset masks the combinational outputs too, so inputs cannot leak through during reset
  assign pc_src = rst_n && pc_src_c;
  assign flush  = rst_n && flush_c;
  assign stall  = rst_n && stall_c;
  assign bubble = rst_n && stall_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (pc_src_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
